// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : bit-serial a+b+cin, one bit per clock, LSB first, registered result
// Revision : 1.0
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] full_d;

    // res_q holds the bits already produced; prepending the current bit gives
    // the complete sum on the last step without an extra shift cycle.
    always_comb begin
        bit_d   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        full_d  = {bit_d, res_q};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= full_d[WIDTH-1:1];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the MSB at this point
                        sum     <= full_d;
                        cout    <= carry_d;
                        ovf     <= carry_q ^ carry_d;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : randomized self-checking bench for serial_adder (WIDTH 8, 2, 32)
// Revision : 1.0
// ============================================================================
module tb_serial_adder;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    logic sys_rst;

    logic        s8_start, s8_cin, s8_busy, s8_done, s8_cout, s8_ovf;
    logic [7:0]  s8_a, s8_b, s8_sum;
    logic        s2_start, s2_cin, s2_busy, s2_done, s2_cout, s2_ovf;
    logic [1:0]  s2_a, s2_b, s2_sum;
    logic        s32_start, s32_cin, s32_busy, s32_done, s32_cout, s32_ovf;
    logic [31:0] s32_a, s32_b, s32_sum;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(s8_start), .a(s8_a), .b(s8_b),
        .cin(s8_cin), .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
    );
    serial_adder #(.WIDTH(2)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(s2_start), .a(s2_a), .b(s2_b),
        .cin(s2_cin), .busy(s2_busy), .done(s2_done), .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf)
    );
    serial_adder #(.WIDTH(32)) u_dut32 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(s32_start), .a(s32_a), .b(s32_b),
        .cin(s32_cin), .busy(s32_busy), .done(s32_done), .sum(s32_sum), .cout(s32_cout), .ovf(s32_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // last completed W8 result, as the outputs should currently hold it
    logic [7:0] m_sum;
    logic       m_cout, m_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // returns {ovf, cout, sum[31:0]} from plain integer arithmetic
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic c);
        logic [63:0] mask, full;
        logic        sx, sy, ss;
        mask = (64'd1 << w) - 64'd1;
        full = (64'(x) & mask) + (64'(y) & mask) + 64'(c);
        sx   = x[w-1];
        sy   = y[w-1];
        ss   = full[w-1];
        return {(sx == sy) && (ss != sx), full[w], full[31:0] & mask[31:0]};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        input bit jitter, input bit spam);
        logic [33:0] r;
        r = ref_add(8, 32'(x), 32'(y), c);
        s8_a = x; s8_b = y; s8_cin = c; s8_start = 1'b1;
        tick();
        chk("accept_busy", 64'(s8_busy), 64'd1);
        s8_start = spam;
        for (int i = 1; i <= 8; i++) begin
            if (jitter || spam) begin
                s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
            end
            tick();
            if (i < 8) begin
                chk("run_no_done", 64'(s8_done), 64'd0);
                chk("run_hold", 64'({s8_ovf, s8_cout, s8_sum}), 64'({m_ovf, m_cout, m_sum}));
            end
        end
        m_sum = r[7:0]; m_cout = r[32]; m_ovf = r[33];
        chk("done", 64'(s8_done), 64'd1);
        chk("sum", 64'(s8_sum), 64'(m_sum));
        chk("cout", 64'(s8_cout), 64'(m_cout));
        chk("ovf", 64'(s8_ovf), 64'(m_ovf));
        chk("busy_in_done", 64'(s8_busy), 64'd1);
        tick();
        chk("done_pulse_end", 64'(s8_done), 64'd0);
        chk("idle_busy", 64'(s8_busy), 64'd0);
        chk("result_held", 64'({s8_ovf, s8_cout, s8_sum}), 64'({m_ovf, m_cout, m_sum}));
    endtask

    task automatic run_n(input int w, input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [33:0] r;
        int          lat;
        logic        seen;
        logic [31:0] g_sum;
        logic        g_cout, g_ovf, g_busy;
        r = ref_add(w, x, y, c);
        if (w == 2) begin
            s2_a = x[1:0]; s2_b = y[1:0]; s2_cin = c; s2_start = 1'b1;
        end else begin
            s32_a = x; s32_b = y; s32_cin = c; s32_start = 1'b1;
        end
        tick();
        s2_start = 1'b0; s32_start = 1'b0;
        s2_a = 2'($urandom); s32_a = $urandom; s2_b = 2'($urandom); s32_b = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < w + 4) begin
            tick();
            lat++;
            seen = (w == 2) ? s2_done : s32_done;
        end
        g_sum  = (w == 2) ? {30'd0, s2_sum} : s32_sum;
        g_cout = (w == 2) ? s2_cout : s32_cout;
        g_ovf  = (w == 2) ? s2_ovf : s32_ovf;
        chk($sformatf("w%0d_latency", w), 64'(lat), 64'(w));
        chk($sformatf("w%0d_sum", w), 64'(g_sum), 64'(r[31:0]));
        chk($sformatf("w%0d_cout", w), 64'(g_cout), 64'(r[32]));
        chk($sformatf("w%0d_ovf", w), 64'(g_ovf), 64'(r[33]));
        tick();
        g_busy = (w == 2) ? s2_busy : s32_busy;
        chk($sformatf("w%0d_idle", w), 64'(g_busy), 64'd0);
    endtask

    initial begin
        sys_rst = 1'b1;
        s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
        s2_start = 1'b0; s2_a = '0; s2_b = '0; s2_cin = 1'b0;
        s32_start = 1'b0; s32_a = '0; s32_b = '0; s32_cin = 1'b0;
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        tick();
        tick();
        chk("rst_outputs", 64'({s8_busy, s8_done, s8_ovf, s8_cout, s8_sum}), 64'd0);
        chk("rst_w2_w32", 64'({s2_busy, s2_done, s32_busy, s32_done}), 64'd0);
        sys_rst = 1'b0;

        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);

        // start held high through RUN/DONE; the follow-on run8 accepts at k+10
        run8(8'h3C, 8'h4D, 1'b1, 1'b0, 1'b1);
        run8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

        // abort at edge k+4 with start asserted alongside reset
        s8_a = 8'h80; s8_b = 8'h80; s8_cin = 1'b1; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("abort_pre_done", 64'(s8_done), 64'd0);
        end
        sys_rst = 1'b1; s8_start = 1'b1;
        tick();
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        chk("abort_outputs", 64'({s8_busy, s8_done, s8_ovf, s8_cout, s8_sum}), 64'd0);
        tick();
        chk("rst_ignores_start", 64'(s8_busy), 64'd0);
        sys_rst = 1'b0; s8_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", 64'({s8_busy, s8_done}), 64'd0);
        end
        run8(8'hC3, 8'h5E, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), (i % 2) == 1, 1'b0);
        end

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    run_n(2, 32'(x), 32'(y), 1'(c));

        run_n(32, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_n(32, 32'h7FFF_FFFF, 32'h1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run_n(32, $urandom, $urandom, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to add a, b and cin; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 SHALL have port cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (RUN or DONE).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking that sum, cout and ovf were just updated.
REQ-010 SHALL have port sum  output  WIDTH  result of a+b+cin, modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 IDLE with start=1 at edge k SHALL load a, b into operand shift registers, load cin into the carry flop, clear the bit counter, and go to RUN.
REQ-015 IDLE with start=0 SHALL hold all state and outputs.
REQ-016 RUN SHALL process one bit per edge, LSB first: bit = a0 XOR b0 XOR c; next c = majority(a0, b0, c).
REQ-017 RUN SHALL shift both operand registers right by one and shift the sum bit into the MSB of an internal result shift register.
REQ-018 For WIDTH bits the operations are done by edges k+1..k+WIDTH.
REQ-019 On edge k+WIDTH the FSM SHALL go to DONE and load sum, cout and ovf from the final result.
REQ-020 ovf SHALL use the carry into bit WIDTH-1, which is the carry flop value before the last bit.
REQ-021 done SHALL be 1 only between edges k+WIDTH and k+WIDTH+1, then the FSM SHALL return to IDLE.
REQ-022 Total latency from accepted start to done SHALL be WIDTH edges; initiation interval SHALL be WIDTH+2 cycles.
REQ-023 busy SHALL be 1 from edge k through edge k+WIDTH+1 exclusive (RUN and DONE) and 0 in IDLE.
REQ-024 start while in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes on a, b or cin after the accepted start edge SHALL NOT affect the result.
REQ-026 sum, cout and ovf SHALL change only on the edge that enters DONE and SHALL hold until the next completion.
REQ-027 The internal shifting result SHALL never be visible on sum.
REQ-028 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide, with no wrap-around before the terminal count.

Reset
REQ-029 When sys_rst=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, sum, cout and ovf SHALL be 0.
REQ-030 Reset SHALL clear the operand registers, the carry flop and the counter.
REQ-031 Reset SHALL take priority over start and over any in-progress RUN or DONE.
REQ-032 An aborted addition SHALL produce no done pulse.
REQ-033 start sampled in the same cycle as sys_rst=1 SHALL be ignored.
REQ-034 The first edge with sys_rst=0 SHALL obey normal IDLE rules.

Verification
REQ-035 WIDTH=8, a=0xFF, b=0x01, cin=0, start at edge k -> at edge k+8: done=1, sum=0x00, cout=1, ovf=0.
REQ-036 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-037 start re-asserted every cycle during RUN and DONE with different a/b -> only the first operands are summed, one done pulse, next accept on the first IDLE edge (k+10).
REQ-038 sys_rst=1 at edge k+4 of a RUN -> busy=0, done never pulses, sum/cout/ovf=0; a fresh start then gives a correct result 8 edges later.
REQ-039 a, b, cin randomized every cycle during RUN -> result equals the values captured at the start edge; sum holds the previous result until done.
REQ-040 Sweep WIDTH=2 and WIDTH=32 with exhaustive (WIDTH=2) or random (WIDTH=32) operands -> {cout,sum} equals a+b+cin, and done occurs exactly WIDTH edges after start.
